// File: rtl/stage_fetch_ifq_pkg.sv
// Shared types for the fetch stage and its instruction fetch queue (IFQ).
package stage_fetch_ifq_pkg;

  localparam int XLEN               = 32;
  localparam int DEF_FETCH_WIDTH    = 4;
  localparam int DEF_DISPATCH_WIDTH = 4;
  localparam int DEF_IFQ_DEPTH      = 16;

  // Packet handed from fetch to decode.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            predict_taken;
    logic [XLEN-1:0] predict_target;
  } if_id_packet_t;

  // An IFQ slot carries exactly the packet decode will see.
  typedef if_id_packet_t ifq_entry_t;

  // The icache returns an aligned 8-byte block; PC[2] picks the 32-bit word.
  function automatic logic [XLEN-1:0] select_word(input logic word_sel, input logic [63:0] block);
    return word_sel ? block[63:32] : block[31:0];
  endfunction

endpackage

// File: rtl/stage_fetch_ifq_if.sv
// Fetch-stage bundle: redirect, branch predictor, icache lanes and decode output.
interface stage_fetch_ifq_if
  import stage_fetch_ifq_pkg::*;
#(
  parameter int FW = DEF_FETCH_WIDTH,
  parameter int DW = DEF_DISPATCH_WIDTH,
  parameter int CW = $clog2(DEF_IFQ_DEPTH) + 1
);
  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;
  logic [XLEN-1:0]        pc_start;
  logic [FW-1:0]          bp_valid;
  logic [FW-1:0]          bp_taken;
  logic [FW-1:0][XLEN-1:0] bp_target;
  logic [FW-1:0]          ic_req_valid;
  logic [FW-1:0][XLEN-1:0] ic_req_addr;
  logic [FW-1:0]          ic_rsp_valid;
  logic [FW-1:0][63:0]    ic_rsp_data;
  // Decode handshake: lane j transfers when id_valid[j] and id_ready are both high
  // in the same cycle; id_valid is contiguous from lane 0 and never depends on id_ready.
  logic                   id_ready;
  logic [DW-1:0]          id_valid;
  if_id_packet_t [DW-1:0] id_packet;
  logic [CW-1:0]          ifq_count;

  modport master (
    input  redirect_valid, redirect_pc, bp_valid, bp_taken, bp_target,
           ic_rsp_valid, ic_rsp_data, id_ready,
    output pc_start, ic_req_valid, ic_req_addr, id_valid, id_packet, ifq_count
  );

  modport slave (
    output redirect_valid, redirect_pc, bp_valid, bp_taken, bp_target,
           ic_rsp_valid, ic_rsp_data, id_ready,
    input  pc_start, ic_req_valid, ic_req_addr, id_valid, id_packet, ifq_count
  );

endinterface

// File: rtl/stage_fetch_ifq_fifo.sv
// Multi-port circular IFQ: up to FW writes and DW reads per cycle, with flush.
module stage_fetch_ifq_fifo
  import stage_fetch_ifq_pkg::*;
#(
  parameter int FW    = DEF_FETCH_WIDTH,
  parameter int DW    = DEF_DISPATCH_WIDTH,
  parameter int DEPTH = DEF_IFQ_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1,
  localparam int KW   = $clog2(FW + 1),
  localparam int RW   = $clog2(DW + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic [KW-1:0]          wr_cnt_i,
  input  ifq_entry_t [FW-1:0]    wr_data_i,
  input  logic [RW-1:0]          rd_cnt_i,
  output ifq_entry_t [DW-1:0]    rd_data_o,
  output logic [CW-1:0]          count_o
);

  ifq_entry_t        mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  // Pointers are exactly PW bits wide so multi-entry moves wrap for free.
  always_comb begin
    head_d  = head_q + PW'(rd_cnt_i);
    tail_d  = tail_q + PW'(wr_cnt_i);
    count_d = count_q + CW'(wr_cnt_i) - CW'(rd_cnt_i);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < FW; i++) begin
      if (!reset && !flush_i && (KW'(i) < wr_cnt_i)) begin
        mem_q[tail_q + PW'(i)] <= wr_data_i[i];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < DW; j++) begin
      rd_data_o[j] = mem_q[head_q + PW'(j)];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stage_fetch_ifq.sv
// Superscalar fetch stage feeding decode through an IFQ.
// Optional FETCH_PERF_CNT_EN adds saturating perf_* counters.
module stage_fetch_ifq
  import stage_fetch_ifq_pkg::*;
#(
  parameter int              FETCH_WIDTH    = DEF_FETCH_WIDTH,
  parameter int              DISPATCH_WIDTH = DEF_DISPATCH_WIDTH,
  parameter int              IFQ_DEPTH      = DEF_IFQ_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC       = '0
) (
  input  logic              clock,
  input  logic              reset,
  stage_fetch_ifq_if.master fif
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_full_cycles,
  output logic [31:0]       perf_redirects
`endif
);

  localparam int PW = $clog2(IFQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(FETCH_WIDTH + 1);
  localparam int RW = $clog2(DISPATCH_WIDTH + 1);

  logic [XLEN-1:0]                   pc_q, pc_d;
  logic [CW-1:0]                     count;
  logic [CW-1:0]                     free_slots;
  logic [FETCH_WIDTH-1:0]            req_valid;
  logic [FETCH_WIDTH-1:0][XLEN-1:0]  lane_addr;
  logic [KW-1:0]                     hit_cnt;
  logic                              prefix_run;
  logic [RW-1:0]                     pop_cnt;
  logic [DISPATCH_WIDTH-1:0]         id_valid;
  ifq_entry_t [FETCH_WIDTH-1:0]      wr_entries;
  ifq_entry_t [DISPATCH_WIDTH-1:0]   rd_entries;

  // Free space uses the registered count only: a same-cycle pop does not make room.
  assign free_slots = CW'(IFQ_DEPTH) - count;

  always_comb begin
    lane_addr[0] = pc_q;
    for (int i = 1; i < FETCH_WIDTH; i++) begin
      lane_addr[i] = fif.bp_target[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      req_valid[i] = fif.bp_valid[i] & ~fif.redirect_valid & ~reset
                   & (int'(free_slots) >= i + 1);
      wr_entries[i].inst           = select_word(lane_addr[i][2], fif.ic_rsp_data[i]);
      wr_entries[i].pc             = lane_addr[i];
      wr_entries[i].npc            = lane_addr[i] + 32'd4;
      wr_entries[i].predict_taken  = fif.bp_taken[i];
      wr_entries[i].predict_target = fif.bp_target[i];
    end
  end

  // Only the leading run of requested-and-hit lanes is kept; later hits are refetched.
  always_comb begin
    hit_cnt    = '0;
    prefix_run = 1'b1;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (prefix_run && req_valid[i] && fif.ic_rsp_valid[i]) begin
        hit_cnt = hit_cnt + KW'(1);
      end else begin
        prefix_run = 1'b0;
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (hit_cnt == KW'(i + 1)) begin
        pc_d = fif.bp_target[i];
      end
    end
    if (fif.redirect_valid) begin
      pc_d = fif.redirect_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_comb begin
    pop_cnt = '0;
    if (fif.id_ready && !fif.redirect_valid && !reset) begin
      pop_cnt = (int'(count) >= DISPATCH_WIDTH) ? RW'(DISPATCH_WIDTH) : RW'(count);
    end
  end

  always_comb begin
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      id_valid[j] = ~fif.redirect_valid & ~reset & (int'(count) > j);
    end
  end

  stage_fetch_ifq_fifo #(
    .FW    (FETCH_WIDTH),
    .DW    (DISPATCH_WIDTH),
    .DEPTH (IFQ_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush_i   (fif.redirect_valid),
    .wr_cnt_i  (hit_cnt),
    .wr_data_i (wr_entries),
    .rd_cnt_i  (pop_cnt),
    .rd_data_o (rd_entries),
    .count_o   (count)
  );

  assign fif.pc_start     = pc_q;
  assign fif.ic_req_valid = req_valid;
  assign fif.ic_req_addr  = lane_addr;
  assign fif.id_valid     = id_valid;
  assign fif.id_packet    = rd_entries;
  assign fif.ifq_count    = count;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_full_q, perf_redir_q;
  logic [32:0] fetched_sum;

  assign fetched_sum = {1'b0, perf_fetched_q} + 33'(hit_cnt);

  // All three counters saturate instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_full_q    <= '0;
      perf_redir_q   <= '0;
    end else begin
      perf_fetched_q <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      if (count == CW'(IFQ_DEPTH) && !fif.redirect_valid && perf_full_q != '1) begin
        perf_full_q <= perf_full_q + 32'd1;
      end
      if (fif.redirect_valid && perf_redir_q != '1) begin
        perf_redir_q <= perf_redir_q + 32'd1;
      end
    end
  end

  assign perf_fetched     = perf_fetched_q;
  assign perf_full_cycles = perf_full_q;
  assign perf_redirects   = perf_redir_q;
`endif

endmodule
